receive: RTL and testbench
==========================

RECEIVE -- requirements
Module: receive

Interface
REQ-001 Parameter FREQ, default 12000000, SHALL be the clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, SHALL be the line rate in bits/s; PERIOD = FREQ/BAUD (integer division), HALF = PERIOD/2.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 rxd  input  1  SHALL be the asynchronous serial line: idle high, 8N1, LSB first.
REQ-006 rdy  input  1  SHALL be consumer ready; a byte is taken on any cycle with stb && rdy.
REQ-007 stb  output  1  SHALL be high while dat holds an untaken byte.
REQ-008 dat  output  8  SHALL be the received byte, stable while stb is high.
REQ-009 frm  output  1  SHALL pulse for one cycle on a framing error.
REQ-010 ovr  output  1  SHALL pulse for one cycle on an overrun.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rs.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT; cnt width $clog2(PERIOD), bit index 0..7.
REQ-013 IDLE: rs==0 SHALL clear cnt and enter START.
REQ-014 START: at cnt==HALF-1, rs==1 SHALL return to IDLE (false start, no flags); rs==0 SHALL clear cnt and enter DATA.
REQ-015 DATA: at each cnt==PERIOD-1, the sampled bit SHALL be shifted in at bit index (LSB first) and cnt cleared; after bit 7, enter STOP.
REQ-016 STOP: at cnt==PERIOD-1, rs==1 SHALL complete the frame and enter IDLE; rs==0 SHALL pulse frm, discard the byte, and enter WAIT.
REQ-017 WAIT: SHALL stay until rs==1, then enter IDLE (no restart on a held-low line).
REQ-018 Frame completion with stb==0, or with stb && rdy in the same cycle, SHALL load dat and set stb on the next edge (1-cycle latency after the stop-bit sample).
REQ-019 Frame completion with stb==1 and rdy==0 SHALL keep the old dat/stb, drop the new byte, and pulse ovr.
REQ-020 stb && rdy with no new completion SHALL clear stb next edge; dat SHALL retain its value.
REQ-021 Reception SHALL continue independently of stb/rdy; back-to-back frames SHALL be received without gaps.
REQ-022 Elaboration SHALL fail if PERIOD < 8.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, cnt 0, index 0, sync flops 1, stb 0, dat 0x00, frm 0, ovr 0.
REQ-024 A reset asserted mid-frame SHALL discard the partial byte; after release the next falling edge SHALL start a fresh frame.

Configuration
REQ-025 With RECEIVE_MAJORITY_EN defined, every bit decision (start, data, stop) SHALL be the 2-of-3 majority of rs at the nominal sample cycle and the cycles immediately before and after; the decision cycle SHALL remain the nominal one plus one cycle of latency.
REQ-026 Without RECEIVE_MAJORITY_EN, each decision SHALL use the single rs sample at the nominal cycle.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state typedef and the FREQ/BAUD default constants; transmit and receive SHALL both use them.
REQ-028 The synchronizer SHALL be sub-module sync2 (2 flops, parameterized reset value), reusable elsewhere.

Verification (FREQ=12000000, BAUD=1000000, PERIOD=12)
REQ-029 Send 0xA5 with rdy=1 -> stb high for exactly 1 cycle, dat=0xA5, frm=ovr=0.
REQ-030 Drive rxd low for 3 cycles while idle -> no stb, no frm; next valid 0x3C frame is received correctly.
REQ-031 Send 0x55 with stop bit low -> frm pulse 1 cycle, stb stays 0; line held low for 40 cycles -> no new frame until rxd returns high.
REQ-032 rdy=0, send 0x11 then 0x22 back-to-back -> dat=0x11, stb=1, ovr pulses once at the second stop bit; raise rdy -> stb clears.
REQ-033 Assert rst_n low during bit 4 of 0xF0 -> all outputs 0 immediately; after release, send 0x0F -> dat=0x0F.
REQ-034 With RECEIVE_MAJORITY_EN: 1-cycle glitch inverting rxd at the midpoint of each data bit of 0x96 -> dat=0x96; without the macro -> dat=0x69.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive blocks:
//   - uart_state_t : frame FSM states (IDLE, START, DATA, STOP, WAIT)
//   - UART_FREQ_DEFAULT / UART_BAUD_DEFAULT : default clock and line rates
//   - majority3   : 2-of-3 vote used by the optional oversampled decisions
// No ports (package).
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_FREQ_DEFAULT = 12000000;
    localparam int UART_BAUD_DEFAULT = 9600;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_WAIT  = 3'd4
    } uart_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync2.sv
// ----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous input bit.
// Parameters:
//   RST_VAL : value both flops take while reset is asserted
// Ports:
//   clk   in  1  destination clock
//   rst_n in  1  asynchronous active-low reset
//   i_d   in  1  asynchronous input
//   o_q   out 1  synchronized output (two clk edges of latency)
// ----------------------------------------------------------------------------
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/receive.sv
// ----------------------------------------------------------------------------
// receive
// 8N1 UART receiver (idle high, LSB first) with a one-byte output holding
// register and stb/rdy handshake.
// Parameters:
//   FREQ : clock frequency in Hz
//   BAUD : line rate in bits/s  (PERIOD = FREQ/BAUD clocks per bit, >= 8)
// Ports:
//   clk   in  1  clock, all state updates on rising edge
//   rst_n in  1  asynchronous active-low reset
//   rxd   in  1  asynchronous serial line
//   rdy   in  1  consumer ready; byte taken on any cycle with stb && rdy
//   stb   out 1  dat holds an untaken byte
//   dat   out 8  received byte, stable while stb is high
//   frm   out 1  one-cycle pulse on a framing error (stop bit low)
//   ovr   out 1  one-cycle pulse when a byte completes while one is pending
// Build option:
//   RECEIVE_MAJORITY_EN : each bit decision is the 2-of-3 vote of the
//   synchronized line around the nominal sample point, taken one clock late.
// ----------------------------------------------------------------------------
module receive
    import uart_pkg::*;
#(
    parameter int FREQ = UART_FREQ_DEFAULT,
    parameter int BAUD = UART_BAUD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       rdy,
    output logic       stb,
    output logic [7:0] dat,
    output logic       frm,
    output logic       ovr
);

    localparam int PERIOD = FREQ / BAUD;
    localparam int HALF   = PERIOD / 2;
    localparam int CW     = $clog2(PERIOD);

    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

    // With voting, the start decision moves one clock later. Because every
    // later decision is measured a whole PERIOD from the start decision, the
    // data and stop decisions inherit the same one-clock delay, which puts
    // the nominal sample in the middle of the three-sample window.
`ifdef RECEIVE_MAJORITY_EN
    localparam logic [CW-1:0] CNT_START = CW'(HALF);
`else
    localparam logic [CW-1:0] CNT_START = CW'(HALF - 1);
`endif

    if (PERIOD < 8) begin : g_period_check
        $error("receive: FREQ/BAUD must be at least 8");
    end

    // ------------------------------------------------------------------
    // Line synchronizer and bit decision
    // ------------------------------------------------------------------
    logic w_rs;
    logic w_bit;

    sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rxd),
        .o_q   (w_rs)
    );

`ifdef RECEIVE_MAJORITY_EN
    logic r_rs_d1;
    logic r_rs_d2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_d1 <= 1'b1;
            r_rs_d2 <= 1'b1;
        end else begin
            r_rs_d1 <= w_rs;
            r_rs_d2 <= r_rs_d1;
        end
    end

    assign w_bit = majority3(w_rs, r_rs_d1, r_rs_d2);
`else
    assign w_bit = w_rs;
`endif

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    uart_state_t   r_state;
    uart_state_t   w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_next;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic          w_done;
    logic          w_ferr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + CW'(1);
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_done       = 1'b0;
        w_ferr       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (!w_rs) begin
                    w_state_next = ST_START;
                end
            end

            ST_START: begin
                if (r_cnt == CNT_START) begin
                    w_cnt_next   = '0;
                    // A line that is high again by mid start bit was noise.
                    w_state_next = w_bit ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next            = '0;
                    w_shift_next[r_idx]   = w_bit;
                    w_idx_next            = r_idx + 3'd1;   // wraps to 0 after bit 7
                    if (r_idx == 3'd7) begin
                        w_state_next = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next = '0;
                    if (w_bit) begin
                        w_done       = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_ferr       = 1'b1;
                        w_state_next = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                // Hold off until the line idles so a stuck-low line (break)
                // does not produce a stream of bogus frames.
                w_cnt_next = '0;
                if (w_rs) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
                w_idx_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output holding register and handshake
    // ------------------------------------------------------------------
    logic       r_stb;
    logic [7:0] r_dat;
    logic       r_frm;
    logic       r_ovr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb <= 1'b0;
            r_dat <= 8'h00;
            r_frm <= 1'b0;
            r_ovr <= 1'b0;
        end else begin
            r_frm <= w_ferr;
            r_ovr <= 1'b0;
            if (w_done) begin
                // A byte taken this cycle frees the register for the new one.
                if (!r_stb || rdy) begin
                    r_dat <= r_shift;
                    r_stb <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_stb && rdy) begin
                r_stb <= 1'b0;
            end
        end
    end

    assign stb = r_stb;
    assign dat = r_dat;
    assign frm = r_frm;
    assign ovr = r_ovr;

endmodule

// File: tb/tb_receive.sv
// ----------------------------------------------------------------------------
// tb_receive
// Directed bench for receive at FREQ=12 MHz, BAUD=1 MBd (12 clocks per bit).
// ----------------------------------------------------------------------------
module tb_receive;

    localparam int FREQ = 12000000;
    localparam int BAUD = 1000000;
    localparam int PER  = FREQ / BAUD;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic       rdy;
    logic       stb;
    logic [7:0] dat;
    logic       frm;
    logic       ovr;

    int n_vec = 0;
    int n_err = 0;

    receive #(
        .FREQ (FREQ),
        .BAUD (BAUD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .rdy   (rdy),
        .stb   (stb),
        .dat   (dat),
        .frm   (frm),
        .ovr   (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running cycle counts of each output, sampled on the falling edge.
    int         stb_cyc = 0;
    int         frm_cyc = 0;
    int         ovr_cyc = 0;
    logic [7:0] last_dat = 8'h00;

    always @(negedge clk) begin
        if (stb) begin
            stb_cyc++;
            last_dat = dat;
        end
        if (frm) frm_cyc++;
        if (ovr) ovr_cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives 'slots' bit times of the frame {stop, d, start}. With glitch set,
    // each data bit is inverted for the one clock around its nominal sample.
    task automatic send_frame(input logic [7:0] d, input logic sb, input bit glitch, input int slots);
        logic [9:0] f;
        f = {sb, d, 1'b0};
        for (int s = 0; s < slots; s++) begin
            for (int c = 0; c < PER; c++) begin
                @(negedge clk);
                if (glitch && s >= 1 && s <= 8 && c == 6) rxd = ~f[s];
                else                                      rxd = f[s];
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int s0, f0, o0;

    initial begin
        rst_n = 1'b0;
        rxd   = 1'b1;
        rdy   = 1'b1;
        #1;
        check("reset_stb", {31'b0, stb}, 32'd0);
        check("reset_dat", {24'b0, dat}, 32'h00);
        check("reset_frm", {31'b0, frm}, 32'd0);
        check("reset_ovr", {31'b0, ovr}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(5);

        // Clean 0xA5, consumer ready
        s0 = stb_cyc; f0 = frm_cyc; o0 = ovr_cyc;
        send_frame(8'hA5, 1'b1, 1'b0, 10);
        idle(4);
        check("a5_stb_cycles", stb_cyc - s0, 32'd1);
        check("a5_dat", {24'b0, last_dat}, 32'hA5);
        check("a5_frm", frm_cyc - f0, 32'd0);
        check("a5_ovr", ovr_cyc - o0, 32'd0);

        // Three-clock low blip is a false start
        s0 = stb_cyc; f0 = frm_cyc;
        @(negedge clk); rxd = 1'b0;
        idle(3);
        rxd = 1'b1;
        idle(30);
        check("blip_stb", stb_cyc - s0, 32'd0);
        check("blip_frm", frm_cyc - f0, 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, 10);
        idle(4);
        check("3c_stb_cycles", stb_cyc - s0, 32'd1);
        check("3c_dat", {24'b0, last_dat}, 32'h3C);

        // 0x55 with a low stop bit, then the line stays low (break)
        s0 = stb_cyc; f0 = frm_cyc;
        send_frame(8'h55, 1'b0, 1'b0, 10);
        idle(2);
        check("ferr_frm_cycles", frm_cyc - f0, 32'd1);
        check("ferr_stb", stb_cyc - s0, 32'd0);
        idle(40);
        check("break_stb", stb_cyc - s0, 32'd0);
        check("break_frm", frm_cyc - f0, 32'd1);
        rxd = 1'b1;
        idle(6);
        send_frame(8'hC3, 1'b1, 1'b0, 10);
        idle(4);
        check("after_break_stb", stb_cyc - s0, 32'd1);
        check("after_break_dat", {24'b0, last_dat}, 32'hC3);

        // Overrun: consumer stalled across two back-to-back frames
        rdy = 1'b0;
        o0 = ovr_cyc; f0 = frm_cyc;
        send_frame(8'h11, 1'b1, 1'b0, 10);
        send_frame(8'h22, 1'b1, 1'b0, 10);
        idle(3);
        check("ovr_cycles", ovr_cyc - o0, 32'd1);
        check("ovr_frm", frm_cyc - f0, 32'd0);
        check("ovr_stb", {31'b0, stb}, 32'd1);
        check("ovr_dat", {24'b0, dat}, 32'h11);
        rdy = 1'b1;
        idle(1);
        check("take_stb", {31'b0, stb}, 32'd0);
        check("take_dat", {24'b0, dat}, 32'h11);

        // Reset in the middle of bit 4 of 0xF0 while a byte is pending
        rdy = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0, 10);
        idle(3);
        check("pre_rst_stb", {31'b0, stb}, 32'd1);
        check("pre_rst_dat", {24'b0, dat}, 32'h5A);
        send_frame(8'hF0, 1'b1, 1'b0, 5);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rxd = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_stb", {31'b0, stb}, 32'd0);
        check("midrst_dat", {24'b0, dat}, 32'h00);
        check("midrst_frm", {31'b0, frm}, 32'd0);
        check("midrst_ovr", {31'b0, ovr}, 32'd0);
        rdy = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(6);
        s0 = stb_cyc; f0 = frm_cyc;
        send_frame(8'h0F, 1'b1, 1'b0, 10);
        idle(4);
        check("post_rst_stb_cycles", stb_cyc - s0, 32'd1);
        check("post_rst_dat", {24'b0, last_dat}, 32'h0F);
        check("post_rst_frm", frm_cyc - f0, 32'd0);

        // Mid-bit glitches on 0x96
        idle(6);
        send_frame(8'h96, 1'b1, 1'b1, 10);
        idle(4);
`ifdef RECEIVE_MAJORITY_EN
        check("glitch_dat", {24'b0, last_dat}, 32'h96);
`else
        check("glitch_dat", {24'b0, last_dat}, 32'h69);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
